// File: rtl/bid_arb_pkg.sv
// bid_arb_pkg: shared state encoding and index-width helper for the bid arbiter
package bid_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bid_arbiter_if.sv
// bid_arbiter_if: request/bid/balance inputs and grant outputs of the bid arbiter
interface bid_arbiter_if import bid_arb_pkg::*; #(
  parameter int NUM_MASTERS = 4,
  parameter int BID_W = 4,
  parameter int BAL_W = 10
) ();
  localparam int IW = idx_w(NUM_MASTERS);
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS*BID_W-1:0] bid;
  logic [NUM_MASTERS*BAL_W-1:0] balance;
  logic done;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] charge;
  logic [IW-1:0] grant_id;
  logic [BID_W-1:0] win_bid;
  logic busy;
  modport master(output req, bid, balance, done, input grant, charge, grant_id, win_bid, busy);
  modport slave(input req, bid, balance, done, output grant, charge, grant_id, win_bid, busy);
endinterface

// File: rtl/bid_select.sv
// bid_select: eligibility filter, highest-bid search, round-robin tie-break from rr_ptr
module bid_select import bid_arb_pkg::*; #(
  parameter int NUM_MASTERS = 4,
  parameter int BID_W = 4,
  parameter int BAL_W = 10,
  localparam int IW = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0]       req,
  input  logic [NUM_MASTERS*BID_W-1:0] bid,
  input  logic [NUM_MASTERS*BAL_W-1:0] balance,
  input  logic [IW-1:0]                rr_ptr,
  output logic                         any_elig,
  output logic [IW-1:0]                win_idx,
  output logic [BID_W-1:0]             win_bid
);
  logic [NUM_MASTERS-1:0] elig;
  int rr, d, best_d;
  assign rr = int'(rr_ptr);
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_elig
    assign elig[i] = req[i] && bid[i*BID_W +: BID_W] != '0 &&
                     balance[i*BAL_W +: BAL_W] > BAL_W'(bid[i*BID_W +: BID_W]);
  end
  // Ties resolve to the smallest upward distance from rr_ptr
  always_comb begin
    any_elig = 1'b0;
    win_idx = '0;
    win_bid = '0;
    best_d = NUM_MASTERS;
    d = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      d = i >= rr ? i - rr : i + NUM_MASTERS - rr;
      if (elig[i] && (!any_elig || bid[i*BID_W +: BID_W] > win_bid ||
          (bid[i*BID_W +: BID_W] == win_bid && d < best_d))) begin
        any_elig = 1'b1;
        win_idx = IW'(i);
        win_bid = bid[i*BID_W +: BID_W];
        best_d = d;
      end
    end
  end
endmodule

// File: rtl/bid_arbiter.sv
// bid_arbiter: sealed-bid arbiter with one-shot charge pulse, hold timeout and round-robin ties
module bid_arbiter import bid_arb_pkg::*; #(
  parameter int NUM_MASTERS = 4,
  parameter int BID_W = 4,
  parameter int BAL_W = 10,
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic rst,
  bid_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t state, state_n;
  logic [NUM_MASTERS-1:0] grant_n, charge_n;
  logic [IW-1:0] id_n, rr_ptr, rr_n, sel_idx;
  logic [BID_W-1:0] wb_n, sel_bid;
  logic [HW-1:0] hold_cnt, hc_n;
  logic any_elig, release_now;
  bid_select #(.NUM_MASTERS(NUM_MASTERS), .BID_W(BID_W), .BAL_W(BAL_W)) u_sel (
    .req(bus.req), .bid(bus.bid), .balance(bus.balance), .rr_ptr(rr_ptr),
    .any_elig(any_elig), .win_idx(sel_idx), .win_bid(sel_bid)
  );
  assign bus.busy = state != IDLE;
  assign release_now = bus.done || !bus.req[bus.grant_id] || hold_cnt == HW'(MAX_HOLD);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.charge <= '0;
      bus.grant_id <= '0;
      bus.win_bid <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      bus.grant <= grant_n;
      bus.charge <= charge_n;
      bus.grant_id <= id_n;
      bus.win_bid <= wb_n;
      rr_ptr <= rr_n;
      hold_cnt <= hc_n;
    end
  end
  // Counter only advances below MAX_HOLD, so it saturates instead of wrapping
  always_comb begin
    state_n = state;
    grant_n = bus.grant;
    charge_n = '0;
    id_n = bus.grant_id;
    wb_n = bus.win_bid;
    hc_n = hold_cnt;
    rr_n = rr_ptr;
    case (state)
      IDLE: if (any_elig) begin
        state_n = GRANT;
        grant_n = NUM_MASTERS'(1) << sel_idx;
        charge_n = NUM_MASTERS'(1) << sel_idx;
        id_n = sel_idx;
        wb_n = sel_bid;
        hc_n = HW'(1);
      end
      GRANT: if (release_now) begin
        state_n = RELEASE;
        grant_n = '0;
      end else hc_n = hold_cnt + HW'(1);
      RELEASE: begin
        state_n = IDLE;
        rr_n = bus.grant_id == IW'(NUM_MASTERS - 1) ? '0 : bus.grant_id + IW'(1);
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_bid_arbiter.sv
// tb_bid_arbiter: directed and random stimulus checked against a transaction-level model
module tb_bid_arbiter;
  localparam int N = 4, BW = 4, LW = 10, MH = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  bid_arbiter_if #(.NUM_MASTERS(N), .BID_W(BW), .BAL_W(LW)) bus ();
  bid_arbiter #(.NUM_MASTERS(N), .BID_W(BW), .BAL_W(LW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int b[N], bl[N];
  int checks = 0, errors = 0;
  int m_owner = -1, m_dead = 0, m_hold = 0, m_rr = 0, m_id = 0, m_wb = 0, m_chg = 0;

  function automatic bit can_win(int i);
    return bus.req[i] && b[i] != 0 && bl[i] > b[i];
  endfunction

  function automatic int pick();
    int best = 0;
    for (int i = 0; i < N; i++) if (can_win(i) && b[i] > best) best = b[i];
    if (best == 0) return -1;
    for (int k = 0; k < N; k++) if (can_win((m_rr + k) % N) && b[(m_rr + k) % N] == best) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int w;
    logic [31:0] eg;
    for (int i = 0; i < N; i++) begin
      bus.bid[i*BW +: BW] = BW'(b[i]);
      bus.balance[i*LW +: LW] = LW'(bl[i]);
    end
    if (!rst) begin
      m_owner = -1; m_dead = 0; m_rr = 0; m_id = 0; m_wb = 0; m_chg = 0; m_hold = 0;
    end else if (m_dead) begin
      m_dead = 0; m_rr = (m_id + 1) % N; m_chg = 0;
    end else if (m_owner >= 0) begin
      m_chg = 0;
      if (bus.done || !bus.req[m_owner] || m_hold == MH) begin
        m_owner = -1; m_dead = 1;
      end else m_hold++;
    end else begin
      w = pick();
      if (w >= 0) begin
        m_owner = w; m_id = w; m_wb = b[w]; m_hold = 1; m_chg = 1;
      end
    end
    @(posedge clk);
    #1;
    eg = m_owner >= 0 ? 32'd1 << m_owner : 32'd0;
    chk("grant", 32'(bus.grant), eg);
    chk("charge", 32'(bus.charge), m_chg != 0 ? eg : 32'd0);
    chk("grant_id", 32'(bus.grant_id), 32'(m_id));
    chk("win_bid", 32'(bus.win_bid), 32'(m_wb));
    chk("busy", 32'(bus.busy), 32'(m_owner >= 0 || m_dead != 0));
    chk("onehot", 32'($onehot0(bus.grant)), 32'd1);
    chk("charge_in_grant", 32'(bus.charge & ~bus.grant), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bus.req = '0; bus.done = 1'b0; bus.bid = '0; bus.balance = '0;
    for (int i = 0; i < N; i++) begin b[i] = 0; bl[i] = 750; end
    tick(); tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_id", 32'(bus.grant_id), 32'd0);
    rst = 1'b1;
    b = '{3, 9, 5, 2};
    bus.req = 4'b1111;
    tick();
    chk("hi_grant", 32'(bus.grant), 32'h2);
    chk("hi_charge", 32'(bus.charge), 32'h2);
    chk("hi_bid", 32'(bus.win_bid), 32'd9);
    tick(); tick();
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    chk("done_release", 32'(bus.grant), 32'd0);
    bus.req = '0; tick(); tick();
    do_reset();
    b = '{0, 7, 7, 0};
    bus.req = 4'b0110;
    tick();
    chk("tie_first", 32'(bus.grant), 32'h2);
    bus.done = 1'b1; tick(); bus.done = 1'b0; tick(); tick();
    chk("tie_second", 32'(bus.grant), 32'h4);
    bus.done = 1'b1; tick(); bus.done = 1'b0; tick(); tick();
    chk("tie_third", 32'(bus.grant), 32'h2);
    bus.req = '0; tick(); tick();
    do_reset();
    b = '{15, 4, 0, 0};
    bl = '{15, 750, 750, 750};
    bus.req = 4'b0011;
    tick();
    chk("afford_skip", 32'(bus.grant), 32'h2);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    bl[0] = 16;
    tick(); tick();
    chk("afford_ok", 32'(bus.grant), 32'h1);
    bus.req = '0; tick();
    chk("drop_release", 32'(bus.grant), 32'd0);
    tick();
    do_reset();
    b = '{5, 0, 0, 0};
    bl = '{750, 750, 750, 750};
    bus.req = 4'b0001;
    for (int c = 0; c < MH; c++) begin
      tick();
      chk("hold_grant", 32'(bus.grant), 32'h1);
    end
    tick();
    chk("timeout_drop", 32'(bus.grant), 32'd0);
    chk("timeout_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("dead_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("rearb", 32'(bus.grant), 32'h1);
    tick();
    rst = 1'b0; tick();
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    tick();
    chk("drop_pre", 32'(bus.charge), 32'h1);
    tick();
    bus.req = '0; tick();
    chk("drop_grant", 32'(bus.grant), 32'd0);
    chk("drop_charge", 32'(bus.charge), 32'd0);
    tick(); tick();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) b[i] = $urandom_range(0, (1 << BW) - 1);
        if ($urandom_range(0, 2) == 0) bl[i] = $urandom_range(0, 3) == 0 ? 750 : $urandom_range(0, 20);
      end
      bus.done = $urandom_range(0, 11) == 0;
      rst = $urandom_range(0, 299) != 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
